// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_ctrl
// Purpose  : Frames the UART byte stream (hdr, len, payload, cksum) into a
//            payload buffer offered to the host with a valid/ack handshake.
//            Optional inter-byte timeout enabled by UART_FRAME_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl #(
    parameter logic [7:0] HDR_BYTE    = 8'hAA,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_rdsig,
    output logic       frm_valid,
    output logic [4:0] frm_len,
    input  logic       frm_ack,
    input  logic [3:0] frm_rd_addr,
    output logic [7:0] frm_rd_data,
    output logic       busy,
    output logic       err_len,
    output logic       err_cksum,
    output logic       err_timeout
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_len     = 3'd1;
    localparam logic [2:0] c_st_payload = 3'd2;
    localparam logic [2:0] c_st_cksum   = 3'd3;
    localparam logic [2:0] c_st_hold    = 3'd4;

    localparam int         c_aw        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] c_max_len8  = 8'(MAX_LEN);
    localparam logic [4:0] c_depth     = 5'(MAX_LEN);

    generate
        if (MAX_LEN < 1 || MAX_LEN > 16 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 4096) begin : g_param_check
            $error("uart_rx_frame_ctrl: parameter out of range");
        end
    endgenerate

    logic       r_rdsig_prev;
    logic       r_byte_stb;
    logic [7:0] r_byte;
    logic [2:0] r_state;
    logic [4:0] r_len;
    logic [4:0] r_idx;
    logic [7:0] r_sum;
    logic       r_err_len;
    logic       r_err_cksum;
    logic       r_err_timeout;
    logic [7:0] r_rd_data;
    logic [7:0] r_buf [0:MAX_LEN-1];
    logic       w_timeout;

    // Previous level resets high so a level already asserted at reset release is not a byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdsig_prev <= 1'b1;
            r_byte_stb   <= 1'b0;
            r_byte       <= 8'h00;
        end else begin
            r_rdsig_prev <= rx_rdsig;
            r_byte_stb   <= rx_rdsig & ~r_rdsig_prev;
            r_byte       <= rx_data;
        end
    end

`ifdef UART_FRAME_TIMEOUT_EN
    logic [11:0] r_to_cnt;
    logic        w_active;

    assign w_active  = (r_state == c_st_len) || (r_state == c_st_payload) ||
                       (r_state == c_st_cksum);
    // A byte landing on the terminal count wins over the timeout.
    assign w_timeout = w_active && !r_byte_stb && (r_to_cnt == 12'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= 12'd0;
        end else if (r_byte_stb || !w_active || w_timeout) begin
            r_to_cnt <= 12'd0;
        end else begin
            r_to_cnt <= r_to_cnt + 12'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_len         <= 5'd0;
            r_idx         <= 5'd0;
            r_sum         <= 8'h00;
            r_err_len     <= 1'b0;
            r_err_cksum   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_len     <= 1'b0;
            r_err_cksum   <= 1'b0;
            r_err_timeout <= 1'b0;
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
                r_state       <= c_st_idle;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (r_byte_stb && (r_byte == HDR_BYTE)) begin
                            r_state <= c_st_len;
                        end
                    end
                    c_st_len: begin
                        if (r_byte_stb) begin
                            if ((r_byte == 8'h00) || (r_byte > c_max_len8)) begin
                                r_err_len <= 1'b1;
                                r_state   <= c_st_idle;
                            end else begin
                                r_len   <= r_byte[4:0];
                                r_sum   <= r_byte;
                                r_idx   <= 5'd0;
                                r_state <= c_st_payload;
                            end
                        end
                    end
                    c_st_payload: begin
                        if (r_byte_stb) begin
                            r_sum <= r_sum + r_byte;
                            r_idx <= r_idx + 5'd1;
                            if (r_idx == (r_len - 5'd1)) begin
                                r_state <= c_st_cksum;
                            end
                        end
                    end
                    c_st_cksum: begin
                        if (r_byte_stb) begin
                            if (r_byte == r_sum) begin
                                r_state <= c_st_hold;
                            end else begin
                                r_err_cksum <= 1'b1;
                                r_state     <= c_st_idle;
                            end
                        end
                    end
                    c_st_hold: begin
                        // Bytes arriving while a frame is held are dropped, even alongside an ack.
                        if (r_byte_stb) begin
                            r_err_len <= 1'b1;
                        end
                        if (frm_ack) begin
                            r_state <= c_st_idle;
                        end
                    end
                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == c_st_payload) && r_byte_stb) begin
            r_buf[r_idx[c_aw-1:0]] <= r_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= 8'h00;
        end else if ({1'b0, frm_rd_addr} < c_depth) begin
            r_rd_data <= r_buf[frm_rd_addr[c_aw-1:0]];
        end
    end

    assign frm_valid   = (r_state == c_st_hold);
    assign busy        = (r_state != c_st_idle);
    assign frm_len     = r_len;
    assign frm_rd_data = r_rd_data;
    assign err_len     = r_err_len;
    assign err_cksum   = r_err_cksum;
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame_ctrl
// Purpose  : Self-checking bench for uart_rx_frame_ctrl: frame-level model
//            compared every cycle plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame_ctrl;

    localparam logic [7:0] c_hdr  = 8'hAA;
    localparam int         c_maxl = 16;
    localparam int         c_toc  = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rdsig = 1'b0;
    logic       frm_ack = 1'b0;
    logic [3:0] frm_rd_addr = 4'd0;
    logic       frm_valid;
    logic [4:0] frm_len;
    logic [7:0] frm_rd_data;
    logic       busy;
    logic       err_len;
    logic       err_cksum;
    logic       err_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    uart_rx_frame_ctrl #(
        .HDR_BYTE   (c_hdr),
        .MAX_LEN    (c_maxl),
        .TIMEOUT_CYC(c_toc)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_rdsig   (rx_rdsig),
        .frm_valid  (frm_valid),
        .frm_len    (frm_len),
        .frm_ack    (frm_ack),
        .frm_rd_addr(frm_rd_addr),
        .frm_rd_data(frm_rd_data),
        .busy       (busy),
        .err_len    (err_len),
        .err_cksum  (err_cksum),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a queue holds the bytes of the frame under construction.
    logic [7:0] q[$];
    logic [7:0] m_buf [16];
    bit         m_known [16];
    bit         m_hold = 1'b0;
    int         m_len = 0;
    int         m_quiet = 0;
    bit         m_prev = 1'b1;
    bit         m_pend = 1'b0;
    logic [7:0] m_pend_b = 8'h00;
    bit         x_err_len = 1'b0;
    bit         x_err_ck = 1'b0;
    bit         x_err_to = 1'b0;
    logic [7:0] x_rd = 8'h00;
    bit         x_rd_known = 1'b1;

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_known[i] = 1'b0;
            m_buf[i]   = 8'h00;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_hold = 1'b0; m_len = 0; m_quiet = 0;
            m_prev = 1'b1; m_pend = 1'b0;
            x_err_len = 1'b0; x_err_ck = 1'b0; x_err_to = 1'b0;
            x_rd = 8'h00; x_rd_known = 1'b1;
        end else begin
            logic [7:0] s;
            x_err_len = 1'b0; x_err_ck = 1'b0; x_err_to = 1'b0;
            x_rd_known = m_known[frm_rd_addr];
            x_rd       = m_buf[frm_rd_addr];
            if (m_pend) begin
                m_quiet = 0;
                if (m_hold) begin
                    x_err_len = 1'b1;
                    if (frm_ack) m_hold = 1'b0;
                end else if (q.size() == 0) begin
                    if (m_pend_b == c_hdr) q.push_back(m_pend_b);
                end else if (q.size() == 1) begin
                    if (m_pend_b == 8'h00 || int'(m_pend_b) > c_maxl) begin
                        x_err_len = 1'b1;
                        q.delete();
                    end else begin
                        m_len = int'(m_pend_b);
                        q.push_back(m_pend_b);
                    end
                end else if (q.size() < m_len + 2) begin
                    m_buf[q.size() - 2]   = m_pend_b;
                    m_known[q.size() - 2] = 1'b1;
                    q.push_back(m_pend_b);
                end else begin
                    // Checksum covers the length byte and every payload byte.
                    s = 8'h00;
                    for (int i = 1; i < q.size(); i++) s = s + q[i];
                    if (s == m_pend_b) m_hold = 1'b1;
                    else x_err_ck = 1'b1;
                    q.delete();
                end
            end else if (m_hold) begin
                if (frm_ack) m_hold = 1'b0;
            end else if (q.size() != 0) begin
`ifdef UART_FRAME_TIMEOUT_EN
                if (m_quiet == c_toc - 1) begin
                    x_err_to = 1'b1;
                    q.delete();
                    m_quiet = 0;
                end else begin
                    m_quiet++;
                end
`endif
            end
            m_pend   = rx_rdsig & ~m_prev;
            m_pend_b = rx_data;
            m_prev   = rx_rdsig;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("frm_valid", frm_valid, m_hold);
            chk("frm_len", frm_len, m_len);
            chk("busy", busy, (q.size() != 0) || m_hold);
            chk("err_len", err_len, x_err_len);
            chk("err_cksum", err_cksum, x_err_ck);
            chk("err_timeout", err_timeout, x_err_to);
            if (x_rd_known) chk("frm_rd_data", frm_rd_data, x_rd);
        end
    end

    int n_len_p = 0;
    int n_ck_p  = 0;
    int n_to_p  = 0;
    always @(negedge clk) begin
        if (err_len)     n_len_p++;
        if (err_cksum)   n_ck_p++;
        if (err_timeout) n_to_p++;
    end

    task automatic send_byte(input logic [7:0] b, input int hi);
        @(negedge clk);
        rx_data  = b;
        rx_rdsig = 1'b1;
        repeat (hi) @(negedge clk);
        rx_rdsig = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] len, input logic [7:0] fill, input logic [7:0] ck);
        send_byte(c_hdr, 1);
        send_byte(len, 1);
        for (int i = 0; i < int'(len); i++) send_byte(fill, 1);
        send_byte(ck, 1);
    endtask

    task automatic do_ack();
        @(negedge clk);
        frm_ack = 1'b1;
        @(negedge clk);
        frm_ack = 1'b0;
    endtask

    task automatic read_chk(input logic [3:0] a, input logic [7:0] exp);
        @(negedge clk);
        frm_rd_addr = a;
        @(negedge clk);
        chk("rd_literal", frm_rd_data, exp);
    endtask

    initial begin
        int p0;
        logic [7:0] exp3 [3];
        exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;

        // Reset with the byte-ready level already high.
        rx_data  = c_hdr;
        rx_rdsig = 1'b1;
        #1 rst = 1'b1;
        #1 cmp_en = 1'b1;
        chk("rst_valid", frm_valid, 1'b0);
        chk("rst_len", frm_len, 5'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_errs", {err_len, err_cksum, err_timeout}, 3'b000);
        chk("rst_rd", frm_rd_data, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rx_rdsig = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_release_busy", busy, 1'b0);

        // Good frame; checksum 03+11+22+33 = 69.
        send_byte(c_hdr, 1);
        send_byte(8'h03, 1);
        for (int i = 0; i < 3; i++) send_byte(exp3[i], 1);
        send_byte(8'h69, 1);
        chk("good_valid", frm_valid, 1'b1);
        chk("good_len", frm_len, 5'd3);
        for (int i = 0; i < 3; i++) read_chk(4'(i), exp3[i]);
        do_ack();
        chk("ack_valid", frm_valid, 1'b0);
        chk("ack_busy", busy, 1'b0);

        // Bad checksum then a one-byte frame.
        p0 = n_ck_p;
        send_byte(c_hdr, 1); send_byte(8'h02, 1); send_byte(8'h10, 1);
        send_byte(8'h20, 1); send_byte(8'h31, 1);
        chk("cksum_pulses", n_ck_p - p0, 1);
        chk("cksum_valid", frm_valid, 1'b0);
        chk("cksum_busy", busy, 1'b0);
        send_frame(8'h01, 8'h05, 8'h06);
        chk("one_valid", frm_valid, 1'b1);
        chk("one_len", frm_len, 5'd1);
        read_chk(4'd0, 8'h05);
        do_ack();

        // Length bounds.
        p0 = n_len_p;
        send_byte(c_hdr, 1); send_byte(8'h00, 1);
        chk("len0_pulse", n_len_p - p0, 1);
        chk("len0_busy", busy, 1'b0);
        p0 = n_len_p;
        send_byte(c_hdr, 1); send_byte(8'h11, 1);
        chk("len17_pulse", n_len_p - p0, 1);
        chk("len17_busy", busy, 1'b0);
        send_frame(8'h10, 8'h01, 8'h20);
        chk("len16_valid", frm_valid, 1'b1);
        chk("len16_len", frm_len, 5'd16);
        read_chk(4'd15, 8'h01);

        // Header while holding is dropped.
        p0 = n_len_p;
        send_byte(c_hdr, 1);
        chk("hold_drop_pulse", n_len_p - p0, 1);
        chk("hold_drop_len", frm_len, 5'd16);
        chk("hold_drop_valid", frm_valid, 1'b1);

        // Ack coinciding with a byte strobe.
        p0 = n_len_p;
        @(negedge clk); rx_data = c_hdr; rx_rdsig = 1'b1;
        @(negedge clk); frm_ack = 1'b1;
        @(negedge clk); frm_ack = 1'b0; rx_rdsig = 1'b0;
        repeat (3) @(negedge clk);
        chk("ack_stb_pulse", n_len_p - p0, 1);
        chk("ack_stb_valid", frm_valid, 1'b0);
        chk("ack_stb_busy", busy, 1'b0);

        // Long byte-ready levels count once each.
        send_byte(c_hdr, 17); send_byte(8'h01, 17);
        send_byte(8'h07, 17); send_byte(8'h08, 17);
        chk("long_valid", frm_valid, 1'b1);
        chk("long_len", frm_len, 5'd1);
        do_ack();

        // Reset mid-payload.
        send_byte(c_hdr, 1); send_byte(8'h04, 1);
        send_byte(8'h01, 1); send_byte(8'h02, 1);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_len", frm_len, 5'd0);
        @(negedge clk); rst = 1'b0;

        // Reset while holding drops frm_valid without a clock edge.
        send_frame(8'h01, 8'h07, 8'h08);
        chk("hold_pre_rst", frm_valid, 1'b1);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        chk("holdrst_valid", frm_valid, 1'b0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        // Partial frame followed by silence.
        send_byte(c_hdr, 1); send_byte(8'h02, 1); send_byte(8'h11, 1);
`ifdef UART_FRAME_TIMEOUT_EN
        p0 = n_to_p;
        repeat (4092) @(negedge clk);
        rx_data = 8'h22; rx_rdsig = 1'b1;
        @(negedge clk); rx_rdsig = 1'b0;
        repeat (3) @(negedge clk);
        chk("to_edge_none", n_to_p - p0, 0);
        chk("to_edge_busy", busy, 1'b1);
        repeat (4200) @(negedge clk);
        chk("to_pulse", n_to_p - p0, 1);
        chk("to_busy", busy, 1'b0);
`else
        repeat (5000) @(negedge clk);
        chk("wait_busy", busy, 1'b1);
        send_byte(8'h22, 1); send_byte(8'h35, 1);
        chk("wait_valid", frm_valid, 1'b1);
        chk("wait_len", frm_len, 5'd2);
        chk("no_timeout", n_to_p, 0);
        do_ack();
`endif
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
